// File: rtl/bcd_to_seven_seg_decoder.sv
// Registered BCD to seven-segment decoder, common-cathode.
// Define BCD_HEX_DECODE_EN to show hex glyphs A-F for codes 10-15.
module bcd_to_seven_seg_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic w,
    input  logic x,
    input  logic y,
    input  logic z,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic invalid
);

    logic [3:0]  code;
    logic [15:0] m;
    logic [6:0]  seg_d;
    logic [6:0]  seg_q;
    logic        inv_d;
    logic        inv_q;

    assign code = {w, x, y, z};

    // One-hot minterm decode of the input code
    always_comb begin
        m = '0;
        m[code] = 1'b1;
    end

    // Each segment is an OR of the minterms that light it
    always_comb begin
        seg_d[6] = m[0] | m[2] | m[3] | m[5] | m[6]
                 | m[7] | m[8] | m[9];
        seg_d[5] = m[0] | m[1] | m[2] | m[3] | m[4]
                 | m[7] | m[8] | m[9];
        seg_d[4] = m[0] | m[1] | m[3] | m[4] | m[5]
                 | m[6] | m[7] | m[8] | m[9];
        seg_d[3] = m[0] | m[2] | m[3] | m[5] | m[6]
                 | m[8] | m[9];
        seg_d[2] = m[0] | m[2] | m[6] | m[8];
        seg_d[1] = m[0] | m[4] | m[5] | m[6] | m[8]
                 | m[9];
        seg_d[0] = m[2] | m[3] | m[4] | m[5] | m[6]
                 | m[8] | m[9];
`ifdef BCD_HEX_DECODE_EN
        seg_d[6] = seg_d[6] | m[10] | m[12] | m[14]
                 | m[15];
        seg_d[5] = seg_d[5] | m[10] | m[13];
        seg_d[4] = seg_d[4] | m[10] | m[11] | m[13];
        seg_d[3] = seg_d[3] | m[11] | m[12] | m[13]
                 | m[14];
        seg_d[2] = seg_d[2] | m[10] | m[11] | m[12]
                 | m[13] | m[14] | m[15];
        seg_d[1] = seg_d[1] | m[10] | m[11] | m[12]
                 | m[14] | m[15];
        seg_d[0] = seg_d[0] | m[10] | m[11] | m[13]
                 | m[14] | m[15];
`endif
    end

    // Non-BCD flag covers codes 10 through 15
    always_comb begin
        inv_d = m[10] | m[11] | m[12] | m[13]
              | m[14] | m[15];
    end

    // Output register; reset blanks the display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= '0;
            inv_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            inv_q <= inv_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_to_seven_seg_decoder.sv
// Directed self-checking bench for the seven-segment decoder.
// Expected patterns are hand-entered from the glyph table.
module tb_bcd_to_seven_seg_decoder;

    logic clk;
    logic rst_n;
    logic w, x, y, z;
    logic a, b, c, d, e, f, g;
    logic invalid;
    logic [6:0] seg;

    int tests;
    int fails;

    bcd_to_seven_seg_decoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .w      (w),
        .x      (x),
        .y      (y),
        .z      (z),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .e      (e),
        .f      (f),
        .g      (g),
        .invalid(invalid)
    );

    assign seg = {a, b, c, d, e, f, g};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input int k);
        case (k)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
`ifdef BCD_HEX_DECODE_EN
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic drive(input int k);
        logic [3:0] v;
        v = k[3:0];
        {w, x, y, z} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8);
        tick();
        tick();
        tests++;
        if (seg !== 7'b0000000 || invalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold seg=%b inv=%b want 0000000/0",
                     seg, invalid);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (seg !== 7'b1111111 || invalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release seg=%b inv=%b want 1111111/0",
                     seg, invalid);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 10; k++) begin
            drive(k);
            tick();
            tests++;
            if (seg !== exp_seg(k) || invalid !== 1'b0) begin
                fails++;
                $display("FAIL sweep_%0d seg=%b inv=%b want %b/0",
                         k, seg, invalid, exp_seg(k));
            end
        end
    endtask

    task automatic test_invalid();
        for (int k = 10; k < 16; k++) begin
            drive(k);
            tick();
            tests++;
            if (seg !== exp_seg(k) || invalid !== 1'b1) begin
                fails++;
                $display("FAIL invalid_%0d seg=%b inv=%b want %b/1",
                         k, seg, invalid, exp_seg(k));
            end
        end
    endtask

    task automatic test_latency();
        drive(2);
        tick();
        tests++;
        if (seg !== 7'b1101101) begin
            fails++;
            $display("FAIL lat_first seg=%b want 1101101", seg);
        end
        drive(7);
        #3;
        tests++;
        if (seg !== 7'b1101101) begin
            fails++;
            $display("FAIL lat_hold seg=%b want 1101101", seg);
        end
        tick();
        tests++;
        if (seg !== 7'b1110000) begin
            fails++;
            $display("FAIL lat_update seg=%b want 1110000", seg);
        end
    endtask

    task automatic test_back_to_back();
        int seq [6] = '{9, 12, 0, 15, 3, 4};
        foreach (seq[i]) begin
            drive(seq[i]);
            tick();
            tests++;
            if (seg !== exp_seg(seq[i]) ||
                invalid !== (seq[i] > 9)) begin
                fails++;
                $display("FAIL b2b_%0d seg=%b inv=%b want %b/%0d",
                         i, seg, invalid, exp_seg(seq[i]),
                         seq[i] > 9);
            end
        end
    endtask

    task automatic test_midstream_reset();
        for (int k = 0; k < 6; k++) begin
            drive(k);
            tick();
        end
        tests++;
        if (seg !== 7'b1011011) begin
            fails++;
            $display("FAIL mid_pre seg=%b want 1011011", seg);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (seg !== 7'b0000000 || invalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset seg=%b inv=%b want 0000000/0",
                     seg, invalid);
        end
        rst_n = 1'b1;
        drive(6);
        tick();
        tests++;
        if (seg !== 7'b1011111 || invalid !== 1'b0) begin
            fails++;
            $display("FAIL mid_release seg=%b inv=%b want 1011111/0",
                     seg, invalid);
        end
        drive(11);
        rst_n = 1'b0;
        tick();
        tests++;
        if (seg !== 7'b0000000 || invalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_over_inv seg=%b inv=%b want 0000000/0",
                     seg, invalid);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        {w, x, y, z} = 4'b0000;
        test_reset();
        test_sweep();
        test_invalid();
        test_latency();
        test_back_to_back();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
